// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: default widths, CDB source indices
// and the round-robin pointer advance used by the CDB arbiter.
package tomasulo_pkg;

   localparam int TOMA_DATA_W = 64;
   localparam int TOMA_TAG_W  = 2;

   localparam int NUM_SRC  = 3;
   localparam int SRC_ADD  = 0;
   localparam int SRC_MULT = 1;
   localparam int SRC_LD   = 2;

   // Pointer lands one past the last winner, wrapping at NUM_SRC.
   function automatic logic [1:0] rr_next(input logic [1:0] k);
      return (k == 2'(NUM_SRC - 1)) ? 2'd0 : k + 2'd1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter3: 3-way round-robin grant, search starts at ptr.
// Ports: req[2:0] requests, ptr[1:0] first candidate, grant one-hot.
module rr_arbiter3 (
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] grant
);

   always_comb begin
      grant = 3'b000;
      case (ptr)
         2'd1: begin
            if (req[1])      grant = 3'b010;
            else if (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
         end
         2'd2: begin
            if (req[2])      grant = 3'b100;
            else if (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
         end
         // ptr==3 never occurs; treat it like 0
         default: begin
            if (req[0])      grant = 3'b001;
            else if (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold register per source (add, mult,
// ld), round-robin broadcast of one result per cycle onto the CDB.
// Ports: clk, rst (sync, active-high), CTRL_flush, per-source
// valid/tag/data/ready, cdb_rob_dest/cdb_data/CTRL_incoming_data.
module cdb_arbiter
   import tomasulo_pkg::*;
#(
   parameter int DATA_W = TOMA_DATA_W,
   parameter int TAG_W  = TOMA_TAG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CTRL_flush,
   input  logic              add_valid,
   input  logic [TAG_W-1:0]  add_tag,
   input  logic [DATA_W-1:0] add_data,
   output logic              add_ready,
   input  logic              mult_valid,
   input  logic [TAG_W-1:0]  mult_tag,
   input  logic [DATA_W-1:0] mult_data,
   output logic              mult_ready,
   input  logic              ld_valid,
   input  logic [TAG_W-1:0]  ld_tag,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic [TAG_W-1:0]  cdb_rob_dest,
   output logic [DATA_W-1:0] cdb_data,
   output logic              CTRL_incoming_data
);

   logic [NUM_SRC-1:0] valid_v;
   logic [NUM_SRC-1:0] ready_v;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] grant;
   logic               live;
   logic [1:0]         gidx;
   logic [1:0]         rr_ptr;

   logic [TAG_W-1:0]   in_tag    [NUM_SRC];
   logic [DATA_W-1:0]  in_data   [NUM_SRC];
   logic [NUM_SRC-1:0] hold_full;
   logic [TAG_W-1:0]   hold_tag  [NUM_SRC];
   logic [DATA_W-1:0]  hold_data [NUM_SRC];

   assign valid_v = {ld_valid, mult_valid, add_valid};

   assign in_tag[SRC_ADD]   = add_tag;
   assign in_tag[SRC_MULT]  = mult_tag;
   assign in_tag[SRC_LD]    = ld_tag;
   assign in_data[SRC_ADD]  = add_data;
   assign in_data[SRC_MULT] = mult_data;
   assign in_data[SRC_LD]   = ld_data;

   // No grants and no acceptance in reset or flush cycles
   assign live    = ~rst & ~CTRL_flush;
   assign req     = hold_full & {NUM_SRC{live}};
   // A granted hold empties at this edge, so it can refill now
   assign ready_v = (~hold_full | grant) & {NUM_SRC{live}};

   assign add_ready  = ready_v[SRC_ADD];
   assign mult_ready = ready_v[SRC_MULT];
   assign ld_ready   = ready_v[SRC_LD];

   rr_arbiter3 u_rr (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   always_comb begin
      gidx = 2'(SRC_ADD);
      unique case (1'b1)
         grant[SRC_MULT]: gidx = 2'(SRC_MULT);
         grant[SRC_LD]:   gidx = 2'(SRC_LD);
         default:         gidx = 2'(SRC_ADD);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full          <= '0;
         rr_ptr             <= 2'd0;
         CTRL_incoming_data <= 1'b0;
         cdb_rob_dest       <= '0;
         cdb_data           <= '0;
      end else if (CTRL_flush) begin
         hold_full          <= '0;
         CTRL_incoming_data <= 1'b0;
      end else begin
         CTRL_incoming_data <= |grant;
         if (|grant) begin
            cdb_rob_dest <= hold_tag[gidx];
            cdb_data     <= hold_data[gidx];
            rr_ptr       <= rr_next(gidx);
         end
         for (int s = 0; s < NUM_SRC; s++) begin
            if (valid_v[s] && ready_v[s]) begin
               hold_full[s] <= 1'b1;
               hold_tag[s]  <= in_tag[s];
               hold_data[s] <= in_data[s];
            end else if (grant[s]) begin
               hold_full[s] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        CTRL_flush = 1'b0;
   logic        add_valid = 1'b0, mult_valid = 1'b0, ld_valid = 1'b0;
   logic [1:0]  add_tag = '0, mult_tag = '0, ld_tag = '0;
   logic [63:0] add_data = '0, mult_data = '0, ld_data = '0;
   logic        add_ready, mult_ready, ld_ready;
   logic [1:0]  cdb_rob_dest;
   logic [63:0] cdb_data;
   logic        CTRL_incoming_data;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk                (clk),
      .rst                (rst),
      .CTRL_flush         (CTRL_flush),
      .add_valid          (add_valid),
      .add_tag            (add_tag),
      .add_data           (add_data),
      .add_ready          (add_ready),
      .mult_valid         (mult_valid),
      .mult_tag           (mult_tag),
      .mult_data          (mult_data),
      .mult_ready         (mult_ready),
      .ld_valid           (ld_valid),
      .ld_tag             (ld_tag),
      .ld_data            (ld_data),
      .ld_ready           (ld_ready),
      .cdb_rob_dest       (cdb_rob_dest),
      .cdb_data           (cdb_data),
      .CTRL_incoming_data (CTRL_incoming_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: pending result per source, rotating priority
   bit          m_full [3];
   logic [1:0]  m_tag  [3];
   logic [63:0] m_data [3];
   int          m_ptr = 0;
   bit          m_ov = 0;
   logic [1:0]  m_otag = '0;
   logic [63:0] m_odata = '0;
   bit [2:0]    m_acc;

   bit          obs_v;
   logic [1:0]  obs_tag;
   logic [63:0] obs_data;
   logic [2:0]  obs_rdy;
   logic [63:0] add_log [$];

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   task automatic step(input bit r, input bit f, input bit [2:0] v,
                       input logic [1:0] t0, input logic [1:0] t1,
                       input logic [1:0] t2, input logic [63:0] d0,
                       input logic [63:0] d1, input logic [63:0] d2);
      logic [1:0]  t [3];
      logic [63:0] d [3];
      int          w;
      int          s;
      bit [2:0]    rdy;
      t[0] = t0; t[1] = t1; t[2] = t2;
      d[0] = d0; d[1] = d1; d[2] = d2;
      @(negedge clk);
      rst = r; CTRL_flush = f;
      add_valid = v[0];  add_tag = t0;  add_data = d0;
      mult_valid = v[1]; mult_tag = t1; mult_data = d1;
      ld_valid = v[2];   ld_tag = t2;   ld_data = d2;
      #1;
      // Winner: first pending source walking from the pointer
      w = -1;
      if (!r && !f) begin
         for (int i = 0; i < 3; i++) begin
            s = (m_ptr + i) % 3;
            if (w < 0 && m_full[s]) w = s;
         end
      end
      for (int i = 0; i < 3; i++)
         rdy[i] = !r && !f && (!m_full[i] || w == i);
      obs_v = CTRL_incoming_data;
      obs_tag = cdb_rob_dest;
      obs_data = cdb_data;
      obs_rdy = {ld_ready, mult_ready, add_ready};
      chk("cdb_valid", 64'(obs_v), 64'(m_ov));
      chk("cdb_dest", 64'(obs_tag), 64'(m_otag));
      chk("cdb_data", obs_data, m_odata);
      chk("ready", 64'(obs_rdy), 64'(rdy));
      if (obs_v && obs_tag == 2'd0) add_log.push_back(obs_data);
      m_acc = rdy & v;
      if (r) begin
         for (int i = 0; i < 3; i++) m_full[i] = 0;
         m_ptr = 0; m_ov = 0; m_otag = '0; m_odata = '0;
      end else if (f) begin
         for (int i = 0; i < 3; i++) m_full[i] = 0;
         m_ov = 0;
      end else begin
         m_ov = (w >= 0);
         if (w >= 0) begin
            m_otag = m_tag[w];
            m_odata = m_data[w];
            m_ptr = (w + 1) % 3;
            m_full[w] = 0;
         end
         for (int i = 0; i < 3; i++) begin
            if (m_acc[i]) begin
               m_full[i] = 1;
               m_tag[i] = t[i];
               m_data[i] = d[i];
            end
         end
      end
   endtask

   task automatic idle();
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic bc(input string n, input logic [1:0] tg,
                     input logic [63:0] dt);
      chk({n, "_v"}, 64'(obs_v), 64'd1);
      chk({n, "_tag"}, 64'(obs_tag), 64'(tg));
      chk({n, "_data"}, obs_data, dt);
   endtask

   logic [63:0] add_q [4];
   int          idx;
   logic [63:0] exp_add [5];

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_full[i] = 0; m_tag[i] = '0; m_data[i] = '0;
      end

      // single result, 2-cycle latency
      step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      idle();
      chk("reset_v", 64'(obs_v), 64'd0);
      chk("reset_dest", 64'(obs_tag), 64'd0);
      chk("reset_data", obs_data, 64'd0);
      chk("reset_ready", 64'(obs_rdy), 64'h7);
      step(0, 0, 3'b001, 2, 0, 0, 64'h1234, 0, 0);
      chk("single_acc", 64'(obs_rdy[0]), 64'd1);
      idle();
      chk("single_c2", 64'(obs_v), 64'd0);
      idle();
      bc("single_c3", 2'd2, 64'h1234);
      idle();
      chk("single_c4", 64'(obs_v), 64'd0);
      chk("single_hold", 64'(obs_tag), 64'd2);

      // contention after reset
      step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      step(0, 0, 3'b111, 0, 1, 3, 64'hA, 64'hB, 64'hC);
      idle();
      idle();
      bc("cont_add", 2'd0, 64'hA);
      idle();
      bc("cont_mult", 2'd1, 64'hB);
      idle();
      bc("cont_ld", 2'd3, 64'hC);
      idle();
      chk("cont_end", 64'(obs_v), 64'd0);

      // rotation: after mult, ld wins over add
      step(0, 0, 3'b010, 0, 1, 0, 0, 64'h31, 0);
      step(0, 0, 3'b101, 0, 0, 2, 64'h30, 0, 64'h32);
      idle();
      bc("rot_mult", 2'd1, 64'h31);
      idle();
      bc("rot_ld", 2'd2, 64'h32);
      idle();
      bc("rot_add", 2'd0, 64'h30);
      idle();

      // back-pressure on add with mult/ld kept full
      add_log.delete();
      add_q[0] = 64'h60; add_q[1] = 64'h70;
      add_q[2] = 64'h80; add_q[3] = 64'h90;
      exp_add[0] = 64'h50; exp_add[1] = 64'h60; exp_add[2] = 64'h70;
      exp_add[3] = 64'h80; exp_add[4] = 64'h90;
      idx = 0;
      step(0, 0, 3'b111, 0, 1, 2, 64'h50, 64'h51, 64'h52);
      for (int k = 0; k < 30; k++) begin
         step(0, 0, {k < 20, k < 20, idx < 4}, 0, 1, 2,
              add_q[idx < 4 ? idx : 0], 64'h100 + 64'(k),
              64'h200 + 64'(k));
         if (k == 0) chk("bp_add_blocked", 64'(obs_rdy[0]), 64'd0);
         if (m_acc[0]) idx++;
      end
      chk("bp_accepted", 64'(idx), 64'd4);
      chk("bp_count", 64'(add_log.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         if (i < add_log.size()) chk("bp_order", add_log[i], exp_add[i]);

      // flush discards all holds
      idle(); idle(); idle();
      step(0, 0, 3'b111, 0, 1, 2, 64'h41, 64'h42, 64'h43);
      step(0, 1, 3'b000, 0, 0, 0, 0, 0, 0);
      chk("flush_rdy", 64'(obs_rdy), 64'd0);
      idle();
      chk("flush_v", 64'(obs_v), 64'd0);
      chk("flush_after_rdy", 64'(obs_rdy), 64'h7);
      idle();
      chk("flush_v2", 64'(obs_v), 64'd0);
      idle();
      chk("flush_v3", 64'(obs_v), 64'd0);

      // reset mid-operation
      step(0, 0, 3'b111, 0, 1, 2, 64'h61, 64'h62, 64'h63);
      idle();
      step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      chk("rst_mid_v", 64'(obs_v), 64'd1);
      step(0, 0, 3'b111, 0, 1, 2, 64'h71, 64'h72, 64'h73);
      chk("rst_out_v", 64'(obs_v), 64'd0);
      chk("rst_out_tag", 64'(obs_tag), 64'd0);
      chk("rst_out_data", obs_data, 64'd0);
      chk("rst_out_rdy", 64'(obs_rdy), 64'h7);
      idle();
      chk("rst_gap", 64'(obs_v), 64'd0);
      idle();
      bc("rst_add", 2'd0, 64'h71);
      idle();
      bc("rst_mult", 2'd1, 64'h72);
      idle();
      bc("rst_ld", 2'd2, 64'h73);
      idle();
      chk("rst_end", 64'(obs_v), 64'd0);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         step(($urandom % 100) < 1, ($urandom % 100) < 3,
              3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
